dd_dispatch_queue: RTL and testbench
====================================

Name: dd_dispatch_queue

Overview:
- In-order staging FIFO directly upstream of the out-of-order divider.
- Accepts 16-bit dividend/divisor pairs ({dividend[15:8], divisor[7:0]}) from a loader via valid/ready.
- Buffers up to DEPTH pairs and presents the head pair to the divider's dispatch unit, which pops it with a single-cycle take pulse when not stalled.
- Counts pairs per job, flags the final pair and divide-by-zero, and pulses job_done once the last pair has been dispatched.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
DATA_W, 16, pair width; upper half is the dividend, lower half is the divisor
JOB_LEN, 32, pairs per job; at least 1

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  begin a job; honoured only in IDLE
in_valid  in  1  loader presents a pair
in_pair  in  DATA_W  {dividend, divisor}
in_ready  out  1  queue accepts in_pair this cycle
out_valid  out  1  head entry valid
out_dividend  out  DATA_W/2  head dividend
out_divisor  out  DATA_W/2  head divisor
out_div_by_zero  out  1  head divisor == 0
out_last  out  1  head is pair number JOB_LEN-1 of the job
out_take  in  1  divider dispatched the head (one-cycle pulse)
occupancy  out  $clog2(DEPTH)+1  entries held
job_done  out  1  one-cycle pulse at end of job
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE; read and write pointers 0; accept and dispatch counters 0.
  - in_ready=0, out_valid=0, out_last=0, out_div_by_zero=0, occupancy=0, job_done=0, busy=0.
  - out_dividend and out_divisor are 0.
  - Reset mid-job discards all contents; no job_done is issued.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - full = MSBs differ and lower bits equal; empty = pointers equal.
  - occupancy = wp - rp.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_ready=0 and out_take is ignored. start=1 clears the pointers and both counters, then goes to RUN next cycle.
  - RUN: in_ready = !full. A push occurs when in_valid && in_ready; the accept counter increments on each push. When the JOB_LEN-th push happens, go to DRAIN next cycle.
  - DRAIN: in_ready=0. When the pop of the pair with dispatch count JOB_LEN-1 occurs, go to DONE.
  - DONE: job_done=1 for exactly one cycle, then IDLE.
- in_ready does not depend on out_take in the same cycle (no pass-through path). A full queue refuses input even when a pop occurs that cycle.
- out_valid = !empty in RUN and DRAIN.
  - Head fields come combinationally from mem[rp].
  - out_div_by_zero = (head divisor == 0).
  - out_last = out_valid && (dispatch counter == JOB_LEN-1).
- Pop happens when out_take && out_valid. out_take while empty is ignored with no pointer change; the bench flags it as a protocol warning.
- Simultaneous push and pop when neither full nor empty: both pointers advance and occupancy is unchanged.
- Push into an empty queue: the data is visible at the head the next cycle (latency 1). Nothing bypasses the queue in the same cycle.
- Divide-by-zero pairs are passed through unchanged. The flag is advisory for the divider.
- start asserted outside IDLE is ignored.
- Counters saturate at JOB_LEN; no further pushes are accepted once JOB_LEN pairs are in.

Decomposition:
- Shared package div_pkg:
  - State localparams: one-hot S_IDLE, S_RUN, S_DRAIN, S_DONE.
  - Default widths: DATA_W, DIV_W = DATA_W/2.
  - JOB_LEN default.
- Sub-module sync_fifo_ptr: a storage array plus full/empty/occupancy logic, parameterized by DEPTH and DATA_W. The top level holds the FSM, the counters and the head decode.

Test Plan:
- Reset, then start, then JOB_LEN pushes at 1 pair/cycle with out_take tied to out_valid:
  - the first push {8'd100, 8'd7} appears with out_valid one cycle later;
  - 32 pops in order;
  - out_last occurs on the 32nd pair;
  - job_done pulses exactly once, then busy=0.
- out_take held 0 while pushing:
  - occupancy reaches 4 and in_ready drops to 0;
  - then pop 1 with in_valid=1: no push that cycle; the push lands on the next cycle and occupancy returns to 4.
- Pair {8'd50, 8'd0} pushed: out_div_by_zero=1 while it is the head; it clears for the following pair {8'd9, 8'd3}.
- out_take pulse while empty: no pointer movement and occupancy stays 0. start pulse during RUN: counters are not cleared.
- Reset asserted asynchronously with 3 entries queued mid-job:
  - outputs go to reset values immediately and no job_done follows;
  - a fresh start/job then completes normally.
- Random in_valid/out_take (50% each, 2000 cycles, JOB_LEN=32, 3 jobs) against a scoreboard queue:
  - dispatch order matches push order;
  - the pointer wrap past DEPTH is exercised;
  - occupancy never exceeds 4.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the divider front-end blocks.
package div_pkg;

    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_DIV_W   = DEFAULT_DATA_W / 2;
    localparam int DEFAULT_JOB_LEN = 32;
    localparam int DEFAULT_DEPTH   = 4;

    // One-hot so each state decodes from a single flop.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_RUN   = 4'b0010,
        S_DRAIN = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

endpackage

// File: rtl/sync_fifo_ptr.sv
// Storage array with extra-MSB read/write pointers for full/empty/occupancy.
module sync_fifo_ptr #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wp;
    logic [AW:0]       rp;
    logic              push_ok;
    logic              pop_ok;

    assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty     = (wp == rp);
    assign occupancy = wp - rp;
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign rdata     = mem[rp[AW-1:0]];

    // Pointers advance independently and wrap through the extra MSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else if (clear) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop_ok)  rp <= rp + 1'b1;
        end
    end

    // Storage is cleared on reset so the head fields read as zero afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_ok && !clear) begin
            mem[wp[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/dd_dispatch_queue.sv
// In-order staging queue feeding the divider; tracks job length and end-of-job.
module dd_dispatch_queue
    import div_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int JOB_LEN = DEFAULT_JOB_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_pair,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_W/2-1:0]     out_dividend,
    output logic [DATA_W/2-1:0]     out_divisor,
    output logic                    out_div_by_zero,
    output logic                    out_last,
    input  logic                    out_take,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    job_done,
    output logic                    busy
);

    localparam int DIV_W = DATA_W / 2;
    localparam int CNT_W = $clog2(JOB_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(JOB_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(JOB_LEN - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  disp_cnt;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              clear;
    logic [DATA_W-1:0] head;

    assign clear     = (state == S_IDLE) && start;
    assign in_ready  = (state == S_RUN) && !full && (acc_cnt < LEN_C);
    assign out_valid = ((state == S_RUN) || (state == S_DRAIN)) && !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_take && out_valid;

    assign out_dividend    = head[DATA_W-1:DIV_W];
    assign out_divisor     = head[DIV_W-1:0];
    assign out_div_by_zero = out_valid && (out_divisor == '0);
    assign out_last        = out_valid && (disp_cnt == LAST_C);
    assign busy            = (state != S_IDLE);

    sync_fifo_ptr #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .wdata     (in_pair),
        .rdata     (head),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Accept/dispatch counters, saturating at the job length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_cnt  <= '0;
            disp_cnt <= '0;
        end else if (clear) begin
            acc_cnt  <= '0;
            disp_cnt <= '0;
        end else begin
            if (push && (acc_cnt < LEN_C))  acc_cnt  <= acc_cnt + 1'b1;
            if (pop && (disp_cnt < LEN_C))  disp_cnt <= disp_cnt + 1'b1;
        end
    end

    // Job sequencing: fill until the last pair is in, drain until it leaves.
    always_comb begin
        state_next = state;
        job_done   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_next = S_RUN;
            end
            S_RUN: begin
                if (push && (acc_cnt == LAST_C)) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && (disp_cnt == LAST_C)) state_next = S_DONE;
            end
            S_DONE: begin
                job_done   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dd_dispatch_queue.sv
// Scoreboard bench for dd_dispatch_queue: a queue model predicts every output each cycle.
module tb_dd_dispatch_queue;

    localparam int DEPTH   = 4;
    localparam int DATA_W  = 16;
    localparam int JOB_LEN = 32;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] in_pair;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_dividend;
    logic [7:0]  out_divisor;
    logic        out_div_by_zero;
    logic        out_last;
    logic        out_take;
    logic [2:0]  occupancy;
    logic        job_done;
    logic        busy;

    dd_dispatch_queue #(
        .DEPTH   (DEPTH),
        .DATA_W  (DATA_W),
        .JOB_LEN (JOB_LEN)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .in_valid        (in_valid),
        .in_pair         (in_pair),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_dividend    (out_dividend),
        .out_divisor     (out_divisor),
        .out_div_by_zero (out_div_by_zero),
        .out_last        (out_last),
        .out_take        (out_take),
        .occupancy       (occupancy),
        .job_done        (job_done),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] sb[$];
    bit          m_run = 0;
    bit          m_active = 0;
    bit          done_pending = 0;
    int          m_acc = 0;
    int          m_disp = 0;
    int          done_pulses = 0;
    int          pops_total = 0;
    int          pushes_total = 0;
    int          last_pops = 0;
    int          max_occ = 0;
    bit          quiet = 0;

    // Values sampled on the most recent tick
    logic        s_valid;
    logic        s_ready;
    logic        s_dbz;
    logic [2:0]  s_occ;
    logic [15:0] s_head;

    function automatic logic [15:0] next_pair();
        return {8'(m_acc * 5 + 1), 8'(m_acc + 2)};
    endfunction

    // One clock cycle: drive at negedge, sample 1ns later, compare against the model, update model.
    // mode: 0 = no take, 1 = take, 2 = take whenever the model expects a valid head.
    task automatic tick(input logic v, input logic [15:0] p, input int mode, input logic st);
        logic exp_ready, exp_valid, exp_last, exp_dbz, exp_done, exp_busy;
        logic [15:0] hd;
        @(negedge clk);
        exp_done  = done_pending;
        exp_busy  = m_active || exp_done;
        exp_ready = m_run && (sb.size() < DEPTH);
        exp_valid = m_active && (sb.size() > 0);
        hd        = exp_valid ? sb[0] : 16'h0000;
        exp_last  = exp_valid && (m_disp == JOB_LEN - 1);
        exp_dbz   = exp_valid && (hd[7:0] == 8'd0);
        start     = st;
        in_valid  = v;
        in_pair   = p;
        out_take  = (mode == 2) ? exp_valid : (mode == 1);
        #1;
        s_valid = out_valid;
        s_ready = in_ready;
        s_dbz   = out_div_by_zero;
        s_occ   = occupancy;
        s_head  = {out_dividend, out_divisor};
        checks++;
        if (in_ready !== exp_ready) begin
            errors++;
            $display("[TB] FAIL in_ready t=%0t got %b expected %b", $time, in_ready, exp_ready);
        end
        checks++;
        if (out_valid !== exp_valid) begin
            errors++;
            $display("[TB] FAIL out_valid t=%0t got %b expected %b", $time, out_valid, exp_valid);
        end
        checks++;
        if (occupancy !== 3'(sb.size())) begin
            errors++;
            $display("[TB] FAIL occupancy t=%0t got %0d expected %0d", $time, occupancy, sb.size());
        end
        checks++;
        if (job_done !== exp_done) begin
            errors++;
            $display("[TB] FAIL job_done t=%0t got %b expected %b", $time, job_done, exp_done);
        end
        checks++;
        if (busy !== exp_busy) begin
            errors++;
            $display("[TB] FAIL busy t=%0t got %b expected %b", $time, busy, exp_busy);
        end
        checks++;
        if (out_last !== exp_last) begin
            errors++;
            $display("[TB] FAIL out_last t=%0t got %b expected %b", $time, out_last, exp_last);
        end
        checks++;
        if (out_div_by_zero !== exp_dbz) begin
            errors++;
            $display("[TB] FAIL out_div_by_zero t=%0t got %b expected %b", $time, out_div_by_zero, exp_dbz);
        end
        if (exp_valid) begin
            checks++;
            if ({out_dividend, out_divisor} !== hd) begin
                errors++;
                $display("[TB] FAIL head_data t=%0t got %h expected %h", $time, {out_dividend, out_divisor}, hd);
            end
        end
        if (occupancy > 3'(max_occ)) max_occ = int'(occupancy);
        if (job_done === 1'b1) done_pulses++;
        if (out_last === 1'b1 && out_take) last_pops++;
        done_pending = 0;
        if (out_take && exp_valid) begin
            void'(sb.pop_front());
            pops_total++;
            if (m_disp == JOB_LEN - 1) begin
                m_active     = 0;
                done_pending = 1;
            end
            m_disp++;
        end else if (out_take && !quiet) begin
            $display("[TB] protocol warning: out_take while queue empty at t=%0t", $time);
        end
        if (v && exp_ready) begin
            sb.push_back(p);
            pushes_total++;
            m_acc++;
            if (m_acc == JOB_LEN) m_run = 0;
        end
        if (st && !exp_busy) begin
            m_run    = 1;
            m_active = 1;
            m_acc    = 0;
            m_disp   = 0;
        end
    endtask

    // Run the current job to its job_done pulse at full rate, bounded.
    task automatic finish_job(input int budget);
        int n = 0;
        while ((m_active || done_pending) && n < budget) begin
            tick(m_run, next_pair(), 2, 0);
            n++;
        end
        checks++;
        if (m_active || done_pending) begin
            errors++;
            $display("[TB] FAIL job_timeout got still_active expected done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 0; in_valid = 0; in_pair = '0; out_take = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, out_div_by_zero, job_done, busy} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b expected 000000",
                     {in_ready, out_valid, out_last, out_div_by_zero, job_done, busy});
        end
        checks++;
        if (occupancy !== 3'd0 || {out_dividend, out_divisor} !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_data got occ=%0d head=%h expected occ=0 head=0000",
                     occupancy, {out_dividend, out_divisor});
        end
        @(negedge clk);
        rst = 1'b1;
        tick(0, 16'h0, 0, 0);
    endtask

    task automatic test_full_job();
        int d0 = done_pulses;
        int p0 = pops_total;
        int l0 = last_pops;
        int n  = 0;
        tick(0, 16'h0, 0, 1);
        tick(1, {8'd100, 8'd7}, 2, 0);
        tick(m_run, next_pair(), 2, 0);
        checks++;
        if (s_valid !== 1'b1 || s_head !== {8'd100, 8'd7}) begin
            errors++;
            $display("[TB] FAIL first_push_latency got valid=%b head=%h expected valid=1 head=6407", s_valid, s_head);
        end
        while ((m_active || done_pending) && n < 200) begin
            tick(m_run, next_pair(), 2, 0);
            n++;
        end
        tick(0, 16'h0, 0, 0);
        checks++;
        if (pops_total - p0 != JOB_LEN) begin
            errors++;
            $display("[TB] FAIL job_pops got %0d expected %0d", pops_total - p0, JOB_LEN);
        end
        checks++;
        if (last_pops - l0 != 1) begin
            errors++;
            $display("[TB] FAIL last_flag_count got %0d expected 1", last_pops - l0);
        end
        checks++;
        if (done_pulses - d0 != 1) begin
            errors++;
            $display("[TB] FAIL job_done_count got %0d expected 1", done_pulses - d0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_after_job got %b expected 0", busy);
        end
    endtask

    task automatic test_backpressure();
        tick(0, 16'h0, 0, 1);
        repeat (6) tick(1, next_pair(), 0, 0);
        tick(0, 16'h0, 0, 0);
        checks++;
        if (s_occ !== 3'd4 || s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_state got occ=%0d ready=%b expected occ=4 ready=0", s_occ, s_ready);
        end
        tick(1, next_pair(), 1, 0);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_pop_no_push got ready=%b expected 0", s_ready);
        end
        tick(1, next_pair(), 0, 0);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL push_after_pop got ready=%b expected 1", s_ready);
        end
        tick(0, 16'h0, 0, 0);
        checks++;
        if (s_occ !== 3'd4) begin
            errors++;
            $display("[TB] FAIL refill_occupancy got %0d expected 4", s_occ);
        end
        finish_job(200);
        tick(0, 16'h0, 0, 0);
    endtask

    task automatic test_div_by_zero();
        tick(0, 16'h0, 0, 1);
        tick(1, {8'd50, 8'd0}, 0, 0);
        tick(1, {8'd9, 8'd3}, 0, 0);
        tick(0, 16'h0, 0, 0);
        checks++;
        if (s_dbz !== 1'b1 || s_head !== {8'd50, 8'd0}) begin
            errors++;
            $display("[TB] FAIL dbz_head got dbz=%b head=%h expected dbz=1 head=3200", s_dbz, s_head);
        end
        tick(0, 16'h0, 1, 0);
        tick(0, 16'h0, 0, 0);
        checks++;
        if (s_dbz !== 1'b0 || s_head !== {8'd9, 8'd3}) begin
            errors++;
            $display("[TB] FAIL dbz_clear got dbz=%b head=%h expected dbz=0 head=0903", s_dbz, s_head);
        end
        finish_job(200);
        tick(0, 16'h0, 0, 0);
    endtask

    task automatic test_empty_take_and_start();
        int d0 = done_pulses;
        int p0 = pushes_total;
        tick(0, 16'h0, 0, 1);
        tick(0, 16'h0, 1, 0);
        tick(0, 16'h0, 0, 0);
        checks++;
        if (s_occ !== 3'd0 || s_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL empty_take got occ=%0d valid=%b expected occ=0 valid=0", s_occ, s_valid);
        end
        tick(1, next_pair(), 0, 0);
        tick(1, next_pair(), 0, 0);
        tick(0, 16'h0, 0, 1);
        finish_job(200);
        tick(0, 16'h0, 0, 0);
        checks++;
        if (pushes_total - p0 != JOB_LEN || done_pulses - d0 != 1) begin
            errors++;
            $display("[TB] FAIL start_in_run got pushes=%0d done=%0d expected pushes=%0d done=1",
                     pushes_total - p0, done_pulses - d0, JOB_LEN);
        end
    endtask

    task automatic test_async_reset();
        int d0;
        tick(0, 16'h0, 0, 1);
        repeat (3) tick(1, next_pair(), 0, 0);
        @(negedge clk);
        in_valid = 0; out_take = 0; start = 0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, out_div_by_zero, job_done, busy} !== 6'b0 ||
            occupancy !== 3'd0 || {out_dividend, out_divisor} !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL async_reset got flags=%b occ=%0d head=%h expected flags=000000 occ=0 head=0000",
                     {in_ready, out_valid, out_last, out_div_by_zero, job_done, busy},
                     occupancy, {out_dividend, out_divisor});
        end
        sb.delete();
        m_run = 0; m_active = 0; done_pending = 0; m_acc = 0; m_disp = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        d0 = done_pulses;
        repeat (3) tick(0, 16'h0, 0, 0);
        checks++;
        if (done_pulses != d0) begin
            errors++;
            $display("[TB] FAIL no_done_after_reset got %0d pulses expected 0", done_pulses - d0);
        end
        d0 = done_pulses;
        tick(0, 16'h0, 0, 1);
        finish_job(200);
        checks++;
        if (done_pulses - d0 != 1) begin
            errors++;
            $display("[TB] FAIL job_after_reset got %0d pulses expected 1", done_pulses - d0);
        end
        tick(0, 16'h0, 0, 0);
    endtask

    task automatic test_random();
        int jobs_started = 0;
        int d0 = done_pulses;
        int p0 = pushes_total;
        logic v;
        int   md;
        quiet   = 1;
        max_occ = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!m_active && !done_pending && jobs_started < 3) begin
                tick(0, 16'h0, 0, 1);
                jobs_started++;
            end else begin
                v  = 1'($urandom_range(0, 1));
                md = int'($urandom_range(0, 1));
                tick(v, 16'($urandom), md, 0);
            end
        end
        quiet = 0;
        checks++;
        if (done_pulses - d0 != 3) begin
            errors++;
            $display("[TB] FAIL random_jobs got %0d expected 3", done_pulses - d0);
        end
        checks++;
        if (pushes_total - p0 != 3 * JOB_LEN) begin
            errors++;
            $display("[TB] FAIL random_pushes got %0d expected %0d", pushes_total - p0, 3 * JOB_LEN);
        end
        checks++;
        if (max_occ > DEPTH || max_occ == 0) begin
            errors++;
            $display("[TB] FAIL random_max_occupancy got %0d expected 1..%0d", max_occ, DEPTH);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_full_job();
        test_backpressure();
        test_div_by_zero();
        test_empty_take_and_start();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
